// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-input round-robin arbitrating multiplexer.
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Round-robin pick: first set bit of req searching upward from last+1, wrapping at 3.
  function automatic logic [1:0] next_rr(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    next_rr = last + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) next_rr = idx;
    end
  endfunction

endpackage

// File: rtl/mux_4x1_w.sv
// W-bit 4-to-1 data multiplexer steered by the arbiter's select.
module mux_4x1_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] in_0,
  input  logic [W-1:0] in_1,
  input  logic [W-1:0] in_2,
  input  logic [W-1:0] in_3,
  input  logic [1:0]   select,
  output logic [W-1:0] m_out
);

  always_comb begin
    m_out = in_0;
    case (select)
      2'd0: m_out = in_0;
      2'd1: m_out = in_1;
      2'd2: m_out = in_2;
      2'd3: m_out = in_3;
      default: m_out = in_0;
    endcase
  end

endmodule

// File: rtl/mux_arb_4x1.sv
// Round-robin 4:1 arbiter with a registered one-hot grant and data mux.
// Define MUX_ARB_TIMEOUT_EN to cap a grant at MAX_BURST transfers when others wait.
module mux_arb_4x1
  import mux_arb_pkg::*;
#(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] in_0,
  input  logic [W-1:0] in_1,
  input  logic [W-1:0] in_2,
  input  logic [W-1:0] in_3,
  input  logic         out_ready,
  output logic [W-1:0] m_out,
  output logic         out_valid,
  output logic [3:0]   gnt,
  output logic [1:0]   select,
  output logic         busy
);

  state_t     state;
  logic [1:0] last_served;
  logic [3:0] others;
  logic [1:0] pick_idle, pick_rel;
  logic       xfer, release_now;

  assign out_valid = (state == GRANT) && req[select];
  assign busy      = (state == GRANT);
  assign xfer      = out_valid && out_ready;
  assign others    = req & ~(4'b0001 << select);
  assign pick_idle = next_rr(req, last_served);
  assign pick_rel  = next_rr(others, select);

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_BURST) + 1;
  logic [CW-1:0] burst_cnt, burst_nxt;

  // Count saturates at MAX_BURST so a lone requester keeps streaming.
  always_comb begin
    burst_nxt = burst_cnt;
    if (xfer && burst_cnt != CW'(MAX_BURST)) burst_nxt = burst_cnt + 1'b1;
  end

  assign release_now = !req[select] ||
                       (xfer && burst_nxt == CW'(MAX_BURST) && |others);
`else
  assign release_now = !req[select];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= 4'b0000;
      select      <= 2'd0;
      last_served <= 2'd3;
`ifdef MUX_ARB_TIMEOUT_EN
      burst_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= GRANT;
            select <= pick_idle;
            gnt    <= 4'b0001 << pick_idle;
`ifdef MUX_ARB_TIMEOUT_EN
            burst_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (release_now) begin
            last_served <= select;
            // Hand straight to the next waiter so there is no idle bubble.
            if (|others) begin
              select <= pick_rel;
              gnt    <= 4'b0001 << pick_rel;
`ifdef MUX_ARB_TIMEOUT_EN
              burst_cnt <= '0;
`endif
            end else begin
              state <= IDLE;
              gnt   <= 4'b0000;
            end
          end else begin
`ifdef MUX_ARB_TIMEOUT_EN
            burst_cnt <= burst_nxt;
`endif
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
        end
      endcase
    end
  end

  mux_4x1_w #(.W(W)) u_mux (
    .in_0   (in_0),
    .in_1   (in_1),
    .in_2   (in_2),
    .in_3   (in_3),
    .select (select),
    .m_out  (m_out)
  );

endmodule

// File: tb/tb_mux_arb_4x1.sv
// Randomized and directed bench for mux_arb_4x1 against a behavioural arbiter model.
module tb_mux_arb_4x1;

  localparam int W    = 8;
  localparam int MAXB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [W-1:0] in_v [4];
  logic         out_ready = 1'b0;
  logic [W-1:0] m_out;
  logic         out_valid;
  logic [3:0]   gnt;
  logic [1:0]   select;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  // Model: whether a grant is live, who holds it, who was last served, transfers this grant.
  bit m_busy;
  int m_sel, m_last, m_cnt;

  always #5 clk = ~clk;

  mux_arb_4x1 #(.W(W), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .in_0      (in_v[0]),
    .in_1      (in_v[1]),
    .in_2      (in_v[2]),
    .in_3      (in_v[3]),
    .out_ready (out_ready),
    .m_out     (m_out),
    .out_valid (out_valid),
    .gnt       (gnt),
    .select    (select),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return (last + 1) % 4;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 0;
    m_last = 3;
    m_cnt  = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input bit rdy);
    bit         xfer;
    bit         rel;
    logic [3:0] oth;
    xfer = m_busy && r[m_sel] && rdy;
    if (!m_busy) begin
      if (r != 4'b0000) begin
        m_sel  = rr_pick(r, m_last);
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      oth = r;
      oth[m_sel] = 1'b0;
      rel = !r[m_sel];
`ifdef MUX_ARB_TIMEOUT_EN
      if (xfer && m_cnt < MAXB) m_cnt++;
      if (xfer && m_cnt == MAXB && oth != 4'b0000) rel = 1'b1;
`endif
      if (rel) begin
        m_last = m_sel;
        if (oth != 4'b0000) begin
          m_sel = rr_pick(oth, m_last);
          m_cnt = 0;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registers after edge.
  task automatic cyc();
    @(negedge clk);
    chk("out_valid", out_valid, m_busy && req[m_sel]);
    chk("m_out", m_out, in_v[m_sel]);
    @(posedge clk);
    model_edge(req, out_ready);
    #1;
    chk("gnt", gnt, m_busy ? (32'd1 << m_sel) : 32'd0);
    chk("select", select, m_sel);
    chk("busy", busy, m_busy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) in_v[i] = W'(8'h10 * (i + 1));
    model_reset();

    // Reset with everyone requesting
    req = 4'b1111;
    out_ready = 1'b1;
    #2;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_select", select, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    chk("first_gnt", gnt, 4'b0001);

    // Rotation: two transfers each, then a one-cycle drop
    for (int g = 0; g < 5; g++) begin
      chk("rot_sel", select, g % 4);
      chk("rot_busy", busy, 1'b1);
      cyc();
      cyc();
      req = ~(4'b0001 << (g % 4));
      cyc();
      req = 4'b1111;
    end

    // Back-pressure on requester 2
    req = 4'b0000;
    do_reset();
    req = 4'b0100;
    in_v[2] = 8'hA5;
    out_ready = 1'b0;
    cyc();
    chk("bp_gnt", gnt, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", m_out, 8'hA5);
      chk("bp_gnt_hold", gnt, 4'b0100);
    end

    // Burst timeout with requester 0 never dropping
    req = 4'b0000;
    do_reset();
    req = 4'b0011;
    out_ready = 1'b1;
    cyc();
    chk("to_first", gnt, 4'b0001);
    for (int i = 0; i < 4; i++) cyc();
`ifdef MUX_ARB_TIMEOUT_EN
    chk("to_moved", gnt, 4'b0010);
`else
    chk("to_held", gnt, 4'b0001);
`endif
    for (int i = 0; i < 6; i++) cyc();

    // Lone requester 3 pulsing: wrap search always lands on 3
    req = 4'b0000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req = 4'b1000;
      cyc();
      chk("single_sel", select, 2'd3);
      chk("single_gnt", gnt, 4'b1000);
      req = 4'b0000;
      cyc();
    end

    // Asynchronous reset in the middle of a grant to requester 1
    do_reset();
    req = 4'b0010;
    cyc();
    cyc();
    chk("mid_gnt_pre", gnt, 4'b0010);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_gnt", gnt, 4'b0000);
    chk("mid_valid", out_valid, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b0000;

    // Random traffic with sticky requests so bursts form
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      for (int i = 0; i < 4; i++) in_v[i] = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arb_4x1.md
MUX_ARB_4X1 -- requirements
Module: mux_arb_4x1

Interface
REQ-001 SHALL have parameter W, default 8: data width of each requester input and of m_out.
REQ-002 SHALL have parameter MAX_BURST, default 4: maximum number of transfers per grant when MUX_ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req, input, 4 bits: req[i] is high while requester i has data on in_i.
REQ-006 SHALL have ports in_0, in_1, in_2 and in_3, input, W bits each: requester data.
REQ-007 SHALL have port out_ready, input, 1 bit: the consumer accepts m_out this cycle.
REQ-008 SHALL have port m_out, output, W bits: data of the granted requester.
REQ-009 SHALL have port out_valid, output, 1 bit: m_out is valid this cycle.
REQ-010 SHALL have port gnt, output, 4 bits: registered one-hot grant, or all zero.
REQ-011 SHALL have port select, output, 2 bits: registered index of the granted requester.
REQ-012 SHALL have port busy, output, 1 bit: high while the state is GRANT.

Function
REQ-013 SHALL have two FSM states: IDLE and GRANT.
REQ-014 SHALL, in IDLE with req nonzero, enter GRANT on the next edge with the requester chosen by round-robin.
  - Search starts at (last_served+1) mod 4.
REQ-015 SHALL, in IDLE with req zero, stay in IDLE with gnt=0.
REQ-016 SHALL keep gnt exactly one-hot in GRANT, with gnt[select]=1.
REQ-017 SHALL drive out_valid combinationally as (state==GRANT) && req[select].
REQ-018 SHALL drive m_out as in_select in every state, including IDLE.
REQ-019 SHALL count a transfer only in a cycle where out_valid && out_ready.
REQ-020 SHALL release the grant on the edge after req[select] is sampled low while in GRANT.
REQ-021 SHALL update last_served to select on release.
REQ-022 SHALL, on release with other requests pending, grant the next round-robin requester on that same edge with no IDLE bubble.
  - If no other request is pending, the next state is IDLE.
REQ-023 SHALL ignore changes on req[j] for j!=select while in GRANT.
REQ-024 SHALL give grant latency from IDLE of exactly 1 cycle: req rises at edge n, gnt is valid after edge n+1.
REQ-025 SHALL wrap the round-robin search from index 3 to index 0.
  - With only one requester active, that requester is re-granted on every arbitration.

Reset
REQ-026 SHALL, while rst is high, asynchronously force state=IDLE, gnt=0, select=0, last_served=3 and burst count=0.
  - Consequence: the first grant after reset favours requester 0.
REQ-027 SHALL abort any grant in progress on rst assertion mid-operation and drop out_valid immediately.
  - No transfer completes in that cycle.

Configuration
REQ-028 SHALL, with macro MUX_ARB_TIMEOUT_EN defined, keep a burst counter of width $clog2(MAX_BURST)+1.
  - Cleared on each new grant; incremented on each transfer.
REQ-029 SHALL, with MUX_ARB_TIMEOUT_EN defined, force release when a transfer makes the count equal MAX_BURST and another req bit is set.
  - The forced release follows REQ-021 and REQ-022.
  - With no other requester pending, the count saturates and the grant holds.
REQ-030 SHALL, without MUX_ARB_TIMEOUT_EN, contain no burst counter; the grant is held until req[select] drops.

Structure
REQ-031 SHALL put the state encoding (IDLE=1'b0, GRANT=1'b1) and the function next_rr(req, last) -> 2-bit index in the shared package mux_arb_pkg.
REQ-032 SHALL instantiate the datapath as sub-module mux_4x1_w, a W-bit 4-to-1 multiplexer.
  - Inputs in_0..in_3, selected by select, output m_out.

Verification
REQ-033 SHALL cover reset: rst=1 with req=4'b1111 -> gnt=0, out_valid=0, select=0; after release, gnt=4'b0001 one cycle later.
REQ-034 SHALL cover rotation: req=4'b1111 held, each requester drops req for one cycle after 2 transfers -> grant order 0,1,2,3,0 with no IDLE cycles between grants.
REQ-035 SHALL cover back-pressure: gnt=4'b0100, in_2=8'hA5, out_ready=0 for 3 cycles -> out_valid=1, m_out=8'hA5 stable, no transfer counted.
REQ-036 SHALL cover timeout with the macro defined and MAX_BURST=4: req=4'b0011, requester 0 never drops, out_ready=1 -> gnt moves to 4'b0010 after exactly 4 transfers.
  - Without the macro: requester 0 holds the grant indefinitely.
REQ-037 SHALL cover the single requester: req=4'b1000 pulsing -> select=3 on every grant; wrap-around search returns index 3.
REQ-038 SHALL cover mid-burst reset: rst asserted mid-cycle while gnt=4'b0010 -> gnt=0 and out_valid=0 immediately, asynchronously.
